// File: rtl/axis_id_demux.sv
// axis_id_demux
//   Unpacks a {tid, tkeep} TUSER stream and routes whole packets to one of
//   NUM_PORTS AXI-Stream masters, chosen by the tid of each packet's first
//   beat. A single output register is shared by all ports: data/keep are
//   broadcast and only the selected port sees tvalid/tlast.
//   Packets whose first-beat tid is >= NUM_PORTS are swallowed.
//
//   Optional feature macro: AXIS_ID_DEMUX_STATS_EN
//     defined   : drop_count / pkt_count counters are built
//     undefined : drop_count / pkt_count are tied to zero
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             slave input stream (tuser = {tid, tkeep})
//   m_axis_tdata/tkeep   per-port slices, all driven from one register
//   m_axis_tlast/tvalid  per-port, at most one valid bit set
//   m_axis_tready        per-port ready
//   drop_count           packets discarded for bad tid
//   pkt_count            packets forwarded per port, 32 bits per port
module axis_id_demux #(
  parameter int DATA_WIDTH  = 8,
  parameter int TID_WIDTH   = 2,
  parameter int TUSER_WIDTH = TID_WIDTH + DATA_WIDTH/8,
  parameter int NUM_PORTS   = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]            s_axis_tuser,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [NUM_PORTS-1:0]              m_axis_tlast,
  output logic [NUM_PORTS-1:0]              m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              m_axis_tready,
  output logic [31:0]                       drop_count,
  output logic [NUM_PORTS*32-1:0]           pkt_count
);

  localparam int KEEP_WIDTH = DATA_WIDTH/8;
  localparam int SEL_SPAN   = 1 << TID_WIDTH;
  localparam logic [TID_WIDTH:0] NUM_PORTS_W = (TID_WIDTH+1)'(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                  state_r, state_next_s;
  logic                    aresetn_q_r;
  logic                    out_valid_r;
  logic                    out_last_r;
  logic [DATA_WIDTH-1:0]   out_data_r;
  logic [KEEP_WIDTH-1:0]   out_keep_r;
  logic [TID_WIDTH-1:0]    sel_r;

  logic [TID_WIDTH-1:0]    in_tid_s;
  logic [KEEP_WIDTH-1:0]   in_keep_s;
  logic                    bad_tid_s;
  logic [SEL_SPAN-1:0]     ready_pad_s;
  logic                    out_ready_s;
  logic                    accept_s;
  logic                    load_s;
  logic                    drain_s;

  assign in_tid_s  = s_axis_tuser[TUSER_WIDTH-1 -: TID_WIDTH];
  assign in_keep_s = s_axis_tuser[KEEP_WIDTH-1:0];
  assign bad_tid_s = ({1'b0, in_tid_s} >= NUM_PORTS_W);

  // Widen per-port ready to the full tid range so sel_r can index it safely.
  always_comb begin
    ready_pad_s = {SEL_SPAN{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      ready_pad_s[i] = m_axis_tready[i];
    end
  end

  assign out_ready_s = ready_pad_s[sel_r];
  assign drain_s     = out_valid_r & out_ready_s;

  // Bad-tid first beats and DROP beats never need the output register.
  assign s_axis_tready = aresetn_q_r &
                         ((state_r == DROP) |
                          ((state_r == IDLE) & bad_tid_s) |
                          !out_valid_r | out_ready_s);
  assign accept_s = s_axis_tvalid & s_axis_tready;
  assign load_s   = accept_s & ((state_r == FWD) | ((state_r == IDLE) & !bad_tid_s));

  // Registered copy of reset gates ready for one cycle after release.
  always_ff @(posedge aclk) begin
    aresetn_q_r <= aresetn;
  end

  // Packet FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Packet FSM next-state: the first beat's tid decides FWD or DROP.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !s_axis_tlast) begin
          state_next_s = bad_tid_s ? DROP : FWD;
        end else begin
          state_next_s = IDLE;
        end
      end
      FWD, DROP: begin
        if (accept_s && s_axis_tlast) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Shared output register; sel only moves when a first beat loads.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_keep_r  <= {KEEP_WIDTH{1'b0}};
      sel_r       <= {TID_WIDTH{1'b0}};
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= s_axis_tlast;
      out_data_r  <= s_axis_tdata;
      out_keep_r  <= in_keep_s;
      if (state_r == IDLE) begin
        sel_r <= in_tid_s;
      end
    end else if (drain_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign m_axis_tdata = {NUM_PORTS{out_data_r}};
  assign m_axis_tkeep = {NUM_PORTS{out_keep_r}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign m_axis_tvalid[p] = out_valid_r & (sel_r == TID_WIDTH'(p));
    assign m_axis_tlast[p]  = out_last_r  & (sel_r == TID_WIDTH'(p));
  end

`ifdef AXIS_ID_DEMUX_STATS_EN
  logic [31:0] drop_cnt_r;
  logic [31:0] pkt_cnt_r [NUM_PORTS];

  // Statistics: drops count at a bad first beat, forwards at an egress tlast.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      drop_cnt_r <= 32'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_r[i] <= 32'd0;
      end
    end else begin
      if (accept_s && (state_r == IDLE) && bad_tid_s) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (drain_s && out_last_r && (sel_r == TID_WIDTH'(i))) begin
          pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
        end
      end
    end
  end

  assign drop_count = drop_cnt_r;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
    assign pkt_count[p*32 +: 32] = pkt_cnt_r[p];
  end
`else
  assign drop_count = 32'd0;
  assign pkt_count  = {(NUM_PORTS*32){1'b0}};
`endif

endmodule

// File: tb/tb_axis_id_demux.sv
module tb_axis_id_demux;

  localparam int DW = 8;
  localparam int TW = 2;
  localparam int KW = DW/8;
  localparam int UW = TW + KW;
  localparam int NP = 3;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [DW-1:0]     s_axis_tdata;
  logic [UW-1:0]     s_axis_tuser;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [NP*DW-1:0]  m_axis_tdata;
  logic [NP*KW-1:0]  m_axis_tkeep;
  logic [NP-1:0]     m_axis_tlast;
  logic [NP-1:0]     m_axis_tvalid;
  logic [NP-1:0]     m_axis_tready;
  logic [31:0]       drop_count;
  logic [NP*32-1:0]  pkt_count;

  axis_id_demux #(
    .DATA_WIDTH(DW), .TID_WIDTH(TW), .TUSER_WIDTH(UW), .NUM_PORTS(NP)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .drop_count(drop_count), .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  int    tests = 0;
  int    fails = 0;

  // Reference model: per-port queues of beats expected to leave, packet counts.
  beat_t exp_q [NP][$];
  int    pkt_exp [NP];
  int    drop_exp;
  bit    in_pkt;
  int    dest;
  bit    stall_v [NP];
  beat_t stall_b [NP];
  bit    last_acc;
  bit    last_ready;
  bit    rand_ready;

  function automatic beat_t out_beat(input int p);
    beat_t b;
    b.d = m_axis_tdata[p*DW +: DW];
    b.k = m_axis_tkeep[p*KW +: KW];
    b.l = m_axis_tlast[p];
    return b;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      pkt_exp[p] = 0;
      stall_v[p] = 1'b0;
    end
    drop_exp = 0;
    in_pkt   = 1'b0;
    dest     = -1;
  endtask

  task automatic set_beat(input logic [DW-1:0] d, input int tid, input logic [KW-1:0] k,
                          input logic l, input logic v);
    s_axis_tdata  = d;
    s_axis_tuser  = {TW'(tid), k};
    s_axis_tlast  = l;
    s_axis_tvalid = v;
  endtask

  // One clock: sample both interfaces just before the edge, update the model, advance.
  task automatic cycle();
    int    tid;
    beat_t ob;
    beat_t eb;
    if (rand_ready) m_axis_tready = NP'($urandom);
    #1;
    last_ready = s_axis_tready;
    last_acc   = s_axis_tvalid & s_axis_tready;
    if (!aresetn) begin
      for (int p = 0; p < NP; p++) stall_v[p] = 1'b0;
    end else begin
      tests++;
      if ($countones(m_axis_tvalid) > 1) begin
        fails++;
        $display("FAIL onehot: m_axis_tvalid=%b, required at most one bit", m_axis_tvalid);
      end
      for (int p = 0; p < NP; p++) begin
        ob = out_beat(p);
        if (stall_v[p]) begin
          tests++;
          if (!m_axis_tvalid[p] || ob !== stall_b[p]) begin
            fails++;
            $display("FAIL stall_hold p%0d: valid=%b beat=%h, required valid=1 beat=%h",
                     p, m_axis_tvalid[p], ob, stall_b[p]);
          end
        end
        stall_v[p] = m_axis_tvalid[p] & !m_axis_tready[p];
        stall_b[p] = ob;
        if (m_axis_tvalid[p] && m_axis_tready[p]) begin
          tests++;
          if (exp_q[p].size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat p%0d: got %h, required nothing", p, ob);
          end else begin
            eb = exp_q[p].pop_front();
            if (ob !== eb) begin
              fails++;
              $display("FAIL out_beat p%0d: got %h, required %h", p, ob, eb);
            end
            if (eb.l) pkt_exp[p]++;
          end
        end
      end
      if (last_acc) begin
        tid = int'(s_axis_tuser[UW-1 -: TW]);
        if (!in_pkt) begin
          dest = (tid < NP) ? tid : -1;
          if (dest < 0) drop_exp++;
        end
        if (dest >= 0) exp_q[dest].push_back({s_axis_tdata, s_axis_tuser[KW-1:0], s_axis_tlast});
        in_pkt = !s_axis_tlast;
      end
    end
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input int tid, input logic [KW-1:0] k,
                           input logic l);
    bit ok = 1'b0;
    set_beat(d, tid, k, l, 1'b1);
    for (int n = 0; n < 64 && !ok; n++) begin
      cycle();
      if (last_acc) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: beat %h not accepted in 64 cycles, required acceptance", d);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 1'b0;
    s_axis_tvalid = 1'b0;
    rand_ready    = 1'b0;
    m_axis_tready = {NP{1'b1}};
    for (int n = 0; n < 32 && !empty; n++) begin
      cycle();
      empty = (m_axis_tvalid == '0);
      for (int p = 0; p < NP; p++) if (exp_q[p].size() != 0) empty = 1'b0;
    end
    tests++;
    if (!empty) begin
      fails++;
      $display("FAIL drain: q0=%0d q1=%0d q2=%0d valid=%b, required all empty",
               exp_q[0].size(), exp_q[1].size(), exp_q[2].size(), m_axis_tvalid);
    end
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    rand_ready    = 1'b0;
    m_axis_tready = {NP{1'b1}};
    cycle();
    cycle();
    aresetn = 1'b1;
    model_reset();
    cycle();
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    m_axis_tready = {NP{1'b1}};
    set_beat(8'h55, 0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests++;
      if (s_axis_tready !== 1'b0) begin
        fails++;
        $display("FAIL reset_ready c%0d: got %b, required 0", i, s_axis_tready);
      end
      tests++;
      if (m_axis_tvalid !== 3'b000) begin
        fails++;
        $display("FAIL reset_valid c%0d: got %b, required 000", i, m_axis_tvalid);
      end
    end
    `ifdef AXIS_ID_DEMUX_STATS_EN
    `endif
    tests++;
    if (drop_count !== 32'd0 || pkt_count !== '0) begin
      fails++;
      $display("FAIL reset_counters: drop=%0d pkt=%h, required 0", drop_count, pkt_count);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d = 8'hA1 + 8'(i);
      send_beat(d, 2, 1'b1, (i == 2));
      tests++;
      if (m_axis_tvalid !== 3'b100 || m_axis_tdata[2*DW +: DW] !== d ||
          m_axis_tkeep[2] !== 1'b1 || m_axis_tlast !== ((i == 2) ? 3'b100 : 3'b000)) begin
        fails++;
        $display("FAIL basic_beat%0d: valid=%b data=%h keep=%b last=%b, required 100 %h 1 %b",
                 i, m_axis_tvalid, m_axis_tdata[2*DW +: DW], m_axis_tkeep[2], m_axis_tlast,
                 d, (i == 2) ? 3'b100 : 3'b000);
      end
    end
    drain();
  endtask

  task automatic test_tid_ignored();
    do_reset();
    send_beat(8'h31, 1, 1'b1, 1'b0);
    tests++;
    if (m_axis_tvalid !== 3'b010) begin
      fails++;
      $display("FAIL tid_first: valid=%b, required 010", m_axis_tvalid);
    end
    send_beat(8'h32, 3, 1'b1, 1'b1);
    tests++;
    if (m_axis_tvalid !== 3'b010 || m_axis_tdata[DW +: DW] !== 8'h32) begin
      fails++;
      $display("FAIL tid_second: valid=%b data=%h, required 010 32", m_axis_tvalid,
               m_axis_tdata[DW +: DW]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    m_axis_tready = 3'b101;
    send_beat(8'h11, 1, 1'b1, 1'b0);
    set_beat(8'h12, 1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests++;
      if (last_ready !== 1'b0 || m_axis_tvalid !== 3'b010 || m_axis_tdata[DW +: DW] !== 8'h11) begin
        fails++;
        $display("FAIL bp_hold c%0d: ready=%b valid=%b data=%h, required 0 010 11",
                 i, last_ready, m_axis_tvalid, m_axis_tdata[DW +: DW]);
      end
    end
    m_axis_tready = 3'b111;
    send_beat(8'h12, 1, 1'b1, 1'b0);
    send_beat(8'h13, 1, 1'b0, 1'b1);
    drain();
    tests++;
    if (pkt_exp[1] != 1) begin
      fails++;
      $display("FAIL bp_packets: model saw %0d packets on p1, required 1", pkt_exp[1]);
    end
  endtask

  task automatic test_bad_tid();
    logic [31:0] exp_drop;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_beat(8'hD0 + 8'(i), 3, 1'b1, (i == 1), 1'b1);
      cycle();
      tests++;
      if (last_ready !== 1'b1 || m_axis_tvalid !== 3'b000) begin
        fails++;
        $display("FAIL drop_beat%0d: ready=%b valid=%b, required 1 000", i, last_ready, m_axis_tvalid);
      end
    end
    drain();
    `ifdef AXIS_ID_DEMUX_STATS_EN
    exp_drop = 32'd1;
    `else
    exp_drop = 32'd0;
    `endif
    tests++;
    if (drop_count !== exp_drop) begin
      fails++;
      $display("FAIL drop_count: got %0d, required %0d", drop_count, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pkt;
    logic [NP-1:0] exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_beat(8'hB0 + 8'(i), i % 2, 1'b1, 1'b1, 1'b1);
      cycle();
      exp_v = (i % 2 == 0) ? 3'b001 : 3'b010;
      tests++;
      if (last_acc !== 1'b1 || m_axis_tvalid !== exp_v) begin
        fails++;
        $display("FAIL b2b_beat%0d: accepted=%b valid=%b, required 1 %b", i, last_acc,
                 m_axis_tvalid, exp_v);
      end
    end
    drain();
    `ifdef AXIS_ID_DEMUX_STATS_EN
    exp_pkt = 32'd2;
    `else
    exp_pkt = 32'd0;
    `endif
    tests++;
    if (pkt_count[31:0] !== exp_pkt || pkt_count[63:32] !== exp_pkt || pkt_count[95:64] !== 32'd0) begin
      fails++;
      $display("FAIL b2b_pkt_count: got %h, required p0=p1=%0d p2=0", pkt_count, exp_pkt);
    end
  endtask

  task automatic test_random();
    int len;
    int tid;
    logic [31:0] exp_drop;
    logic [31:0] exp_pkt;
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      len = int'($urandom_range(1, 4));
      tid = int'($urandom_range(0, 3));
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          set_beat(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 1'b0);
          cycle();
        end
        send_beat(8'($urandom), (b == 0) ? tid : int'($urandom_range(0, 3)), 1'($urandom),
                  (b == len - 1));
      end
    end
    drain();
    for (int p = 0; p < NP; p++) begin
      `ifdef AXIS_ID_DEMUX_STATS_EN
      exp_pkt = 32'(pkt_exp[p]);
      `else
      exp_pkt = 32'd0;
      `endif
      tests++;
      if (pkt_count[p*32 +: 32] !== exp_pkt) begin
        fails++;
        $display("FAIL rand_pkt_count p%0d: got %0d, required %0d", p, pkt_count[p*32 +: 32], exp_pkt);
      end
    end
    `ifdef AXIS_ID_DEMUX_STATS_EN
    exp_drop = 32'(drop_exp);
    `else
    exp_drop = 32'd0;
    `endif
    tests++;
    if (drop_count !== exp_drop) begin
      fails++;
      $display("FAIL rand_drop_count: got %0d, required %0d", drop_count, exp_drop);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    m_axis_tready = {NP{1'b1}};
    rand_ready    = 1'b0;
    set_beat(8'h00, 0, 1'b0, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_basic();
    test_tid_ignored();
    test_backpressure();
    test_bad_tid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
